// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg: shared types and constants for the DMA bus arbiter.
//   bus_owner_t  - which agent currently drives the RAM bus
//   arb_state_t  - arbiter FSM states
//   MAX_GRANT_CYCLES_DEFAULT - default watchdog limit in grant cycles
package dma_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_CPU = 2'd0,
        OWNER_TX  = 2'd1,
        OWNER_RX  = 2'd2
    } bus_owner_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CPU = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } arb_state_t;

    localparam int unsigned MAX_GRANT_CYCLES_DEFAULT = 64;

    // The DMA that is not 'o'. CPU maps to TX so the result is always a DMA.
    function automatic bus_owner_t other_dma(bus_owner_t o);
        return (o == OWNER_TX) ? OWNER_RX : OWNER_TX;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if: all handshake and RAM-bus signals around the arbiter.
//   slave  modport - the arbiter's view (requests/bus sources in, grants/muxed bus out)
//   master modport - the agents' view (CPU, DMA TX, DMA RX, RAM side)
interface dma_bus_arbiter_if;
    import dma_bus_arbiter_pkg::*;

    logic       Tx_Bus_req;
    logic       Tx_Bus_grant;
    logic [7:0] Tx_Address;
    logic       Tx_Cs;
    logic       Tx_Oen;

    logic       Rx_Bus_req;
    logic       Rx_Bus_grant;
    logic [7:0] Rx_Address;
    logic       Rx_Cs;
    logic       Rx_Wen;
    logic [7:0] Rx_Dataout;

    logic       Cpu_Bus_req;
    logic       Cpu_Bus_grant;
    logic [7:0] Cpu_Address;
    logic       Cpu_Cs;
    logic       Cpu_Oen;
    logic       Cpu_Wen;
    logic [7:0] Cpu_Dataout;

    logic [7:0] Address;
    logic       Cs;
    logic       Oen;
    logic       Wen;
    logic [7:0] Dataout;
    bus_owner_t Owner;

    logic       Timeout_clr;
    logic       Arb_timeout;

    modport slave (
        input  Tx_Bus_req, Tx_Address, Tx_Cs, Tx_Oen,
        input  Rx_Bus_req, Rx_Address, Rx_Cs, Rx_Wen, Rx_Dataout,
        input  Cpu_Bus_grant, Cpu_Address, Cpu_Cs, Cpu_Oen, Cpu_Wen, Cpu_Dataout,
        input  Timeout_clr,
        output Tx_Bus_grant, Rx_Bus_grant, Cpu_Bus_req,
        output Address, Cs, Oen, Wen, Dataout, Owner,
        output Arb_timeout
    );

    modport master (
        output Tx_Bus_req, Tx_Address, Tx_Cs, Tx_Oen,
        output Rx_Bus_req, Rx_Address, Rx_Cs, Rx_Wen, Rx_Dataout,
        output Cpu_Bus_grant, Cpu_Address, Cpu_Cs, Cpu_Oen, Cpu_Wen, Cpu_Dataout,
        output Timeout_clr,
        input  Tx_Bus_grant, Rx_Bus_grant, Cpu_Bus_req,
        input  Address, Cs, Oen, Wen, Dataout, Owner,
        input  Arb_timeout
    );

endinterface

// File: rtl/dma_bus_arbiter_bus_mux.sv
// dma_bus_arbiter_bus_mux: combinational RAM-bus source select.
//   state, sel           - arbiter state and selected DMA
//   cpu_*/tx_*/rx_*      - candidate bus sources
//   address..dataout     - muxed RAM bus
//   owner                - current bus owner
// IDLE/WAIT_CPU pass the CPU, GRANT passes the selected DMA, RELEASE drives zeros.
module dma_bus_arbiter_bus_mux
    import dma_bus_arbiter_pkg::*;
(
    input  arb_state_t state,
    input  bus_owner_t sel,
    input  logic [7:0] cpu_address,
    input  logic       cpu_cs,
    input  logic       cpu_oen,
    input  logic       cpu_wen,
    input  logic [7:0] cpu_dataout,
    input  logic [7:0] tx_address,
    input  logic       tx_cs,
    input  logic       tx_oen,
    input  logic [7:0] rx_address,
    input  logic       rx_cs,
    input  logic       rx_wen,
    input  logic [7:0] rx_dataout,
    output logic [7:0] address,
    output logic       cs,
    output logic       oen,
    output logic       wen,
    output logic [7:0] dataout,
    output bus_owner_t owner
);

    always_comb begin
        address = 8'h00;
        cs      = 1'b0;
        oen     = 1'b0;
        wen     = 1'b0;
        dataout = 8'h00;
        owner   = OWNER_CPU;
        case (state)
            IDLE, WAIT_CPU: begin
                address = cpu_address;
                cs      = cpu_cs;
                oen     = cpu_oen;
                wen     = cpu_wen;
                dataout = cpu_dataout;
            end
            GRANT: begin
                owner = sel;
                if (sel == OWNER_TX) begin
                    // TX only reads RAM: write-enable and data stay low
                    address = tx_address;
                    cs      = tx_cs;
                    oen     = tx_oen;
                end else begin
                    // RX only writes RAM: output-enable stays low
                    address = rx_address;
                    cs      = rx_cs;
                    wen     = rx_wen;
                    dataout = rx_dataout;
                end
            end
            default: ; // RELEASE: bus parked at zero
        endcase
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the RAM bus between the CPU and two DMA engines.
//   Clk, Rst - clock, synchronous active-high reset
//   bus      - dma_bus_arbiter_if.slave: requests/grants, CPU handshake, bus sources,
//              muxed RAM bus, Owner, Timeout_clr / Arb_timeout
// The CPU owns the bus until a DMA request is acknowledged via Cpu_Bus_grant. TX/RX
// contention is round-robin on the last served DMA. A watchdog raises a sticky flag
// once a grant has lasted MAX_GRANT_CYCLES cycles; the grant itself is never revoked.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_GRANT_CYCLES = MAX_GRANT_CYCLES_DEFAULT
) (
    input logic              Clk,
    input logic              Rst,
    dma_bus_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_GRANT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_GRANT_CYCLES);

    arb_state_t      state_q, state_d;
    bus_owner_t      sel_q, sel_d;
    bus_owner_t      last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            tmo_q, tmo_d;
    logic            sel_req, oth_req;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            sel_q   <= OWNER_TX;
            last_q  <= OWNER_RX;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        sel_req = (sel_q == OWNER_TX) ? bus.Tx_Bus_req : bus.Rx_Bus_req;
        oth_req = (sel_q == OWNER_TX) ? bus.Rx_Bus_req : bus.Tx_Bus_req;
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

        case (state_q)
            IDLE: begin
                if (bus.Tx_Bus_req || bus.Rx_Bus_req) begin
                    state_d = WAIT_CPU;
                    if (bus.Tx_Bus_req && bus.Rx_Bus_req) begin
                        sel_d = other_dma(last_q);
                    end else begin
                        sel_d = bus.Tx_Bus_req ? OWNER_TX : OWNER_RX;
                    end
                end
            end
            WAIT_CPU: begin
                if (!sel_req) begin
                    state_d = RELEASE;
                end else if (bus.Cpu_Bus_grant) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                cnt_d = cnt_inc;
                if (!sel_req || !bus.Cpu_Bus_grant) begin
                    state_d = RELEASE;
                    last_d  = sel_q;
                end
            end
            default: begin
                // RELEASE: hand straight over if the CPU still has the bus parked
                if (oth_req && bus.Cpu_Bus_grant) begin
                    sel_d   = other_dma(sel_q);
                    state_d = GRANT;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Clear first so a coincident set wins
        if (bus.Timeout_clr) begin
            tmo_d = 1'b0;
        end
        if (state_q == GRANT && cnt_inc == CntMax) begin
            tmo_d = 1'b1;
        end
    end

    assign bus.Tx_Bus_grant = (state_q == GRANT) && (sel_q == OWNER_TX);
    assign bus.Rx_Bus_grant = (state_q == GRANT) && (sel_q == OWNER_RX);
    assign bus.Cpu_Bus_req  = (state_q != IDLE);
    assign bus.Arb_timeout  = tmo_q;

    dma_bus_arbiter_bus_mux u_bus_mux (
        .state       (state_q),
        .sel         (sel_q),
        .cpu_address (bus.Cpu_Address),
        .cpu_cs      (bus.Cpu_Cs),
        .cpu_oen     (bus.Cpu_Oen),
        .cpu_wen     (bus.Cpu_Wen),
        .cpu_dataout (bus.Cpu_Dataout),
        .tx_address  (bus.Tx_Address),
        .tx_cs       (bus.Tx_Cs),
        .tx_oen      (bus.Tx_Oen),
        .rx_address  (bus.Rx_Address),
        .rx_cs       (bus.Rx_Cs),
        .rx_wen      (bus.Rx_Wen),
        .rx_dataout  (bus.Rx_Dataout),
        .address     (bus.Address),
        .cs          (bus.Cs),
        .oen         (bus.Oen),
        .wen         (bus.Wen),
        .dataout     (bus.Dataout),
        .owner       (bus.Owner)
    );

endmodule
